// File: rtl/quad_pwm_bridge_if.sv
// quad_pwm_bridge_if -- signal bundle for the quad_pwm_bridge block.
//
// Groups the encoder inputs, configuration inputs and PWM/position outputs
// so that integrators can pass them around as one object. The bridge itself
// keeps discrete ports; the bundle's members carry the same names as those
// ports, so the connection is one-to-one.
//
// Parameters: CH (encoder channels), PW (position / PWM width).
// Members:
//   A, B      encoder phases, one bit per channel
//   Z         index pulse per channel (only when QPB_INDEX_EN is defined)
//   PPR       counts per revolution, shared by all channels
//   Rate      PWM tick divider
//   Position  packed per-channel counts, channel n in [n*PW +: PW]
//   pwm       per-channel PWM output
//   frame     one-cycle pulse at each PWM frame start
//   err       sticky illegal-transition flags
// Modports: master drives the inputs of the bridge, slave is the bridge view.
interface quad_pwm_bridge_if #(
  parameter int CH = 2,
  parameter int PW = 10
);
  logic [CH-1:0]    A;
  logic [CH-1:0]    B;
`ifdef QPB_INDEX_EN
  logic [CH-1:0]    Z;
`endif
  logic [PW-1:0]    PPR;
  logic [23:0]      Rate;
  logic [CH*PW-1:0] Position;
  logic [CH-1:0]    pwm;
  logic             frame;
  logic [CH-1:0]    err;

`ifdef QPB_INDEX_EN
  modport master (output A, B, Z, PPR, Rate,
                  input  Position, pwm, frame, err);
  modport slave  (input  A, B, Z, PPR, Rate,
                  output Position, pwm, frame, err);
`else
  modport master (output A, B, PPR, Rate,
                  input  Position, pwm, frame, err);
  modport slave  (input  A, B, PPR, Rate,
                  output Position, pwm, frame, err);
`endif
endinterface

// File: rtl/quad_pwm_bridge.sv
// quad_pwm_bridge -- multi-channel quadrature decoder feeding per-channel PWM.
//
// Each channel synchronises its A/B phases, decodes quadrature steps into a
// position count that wraps modulo PPR, and flags illegal (double-bit)
// transitions. A shared divider/frame counter produces a PWM frame of 2^PW
// ticks; each channel latches its count as duty at frame start.
//
// Optional feature: define QPB_INDEX_EN to add the Z index input; a
// synchronised rising edge of Z[n] clears count n.
//
// Ports:
//   clk       single clock, rising edge
//   reset     asynchronous, active-low reset
//   A, B      [CH] encoder phases, asynchronous to clk
//   Z         [CH] index pulses (QPB_INDEX_EN only), asynchronous to clk
//   PPR       [PW] counts per revolution, shared by all channels
//   Rate      [24] PWM tick divider (0 or 1 = tick every cycle)
//   Position  [CH*PW] count of channel n in [n*PW +: PW]
//   pwm       [CH] registered PWM outputs
//   frame     one-cycle pulse on the cycle a frame starts
//   err       [CH] sticky illegal-transition flags
module quad_pwm_bridge #(
  parameter int CH = 2,
  parameter int PW = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CH-1:0]    A,
  input  logic [CH-1:0]    B,
`ifdef QPB_INDEX_EN
  input  logic [CH-1:0]    Z,
`endif
  input  logic [PW-1:0]    PPR,
  input  logic [23:0]      Rate,
  output logic [CH*PW-1:0] Position,
  output logic [CH-1:0]    pwm,
  output logic             frame,
  output logic [CH-1:0]    err
);

  // Gray position of an (A,B) pair along the forward sequence 00,01,11,10.
  function automatic logic [1:0] gray_idx(input logic a, input logic b);
    case ({a, b})
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  logic [CH-1:0] a_s1_q, a_s1_d, a_s2_q, a_s2_d, a_prev_q, a_prev_d;
  logic [CH-1:0] b_s1_q, b_s1_d, b_s2_q, b_s2_d, b_prev_q, b_prev_d;

  logic [CH-1:0][PW-1:0] count_q, count_d;
  logic [CH-1:0][PW-1:0] duty_q, duty_d;
  logic [CH-1:0]         err_q, err_d;
  logic [CH-1:0]         pwm_q, pwm_d;
  logic [23:0]           div_q, div_d;
  logic [PW-1:0]         fcnt_q, fcnt_d;
  logic                  frame_q, frame_d;

  logic [CH-1:0][1:0] cur_idx, prev_idx;
  logic [CH-1:0]      step_inc, step_dec, step_bad;
  logic [CH-1:0]      idx_clear;
  logic [PW-1:0]      ppr_m1;
  logic               ppr_small;
  logic [23:0]        rate_m1;
  logic               tick, wrap;

  assign ppr_m1    = PPR - PW'(1);
  assign ppr_small = (PPR < PW'(2));

  // Two synchroniser stages plus a "previous" stage per phase bit.
  always_comb begin
    a_s1_d   = A;
    a_s2_d   = a_s1_q;
    a_prev_d = a_s2_q;
    b_s1_d   = B;
    b_s2_d   = b_s1_q;
    b_prev_d = b_s2_q;
  end

`ifdef QPB_INDEX_EN
  logic [CH-1:0] z_s1_q, z_s1_d, z_s2_q, z_s2_d, z_prev_q, z_prev_d;

  always_comb begin
    z_s1_d   = Z;
    z_s2_d   = z_s1_q;
    z_prev_d = z_s2_q;
  end

  assign idx_clear = z_s2_q & ~z_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      z_s1_q   <= '0;
      z_s2_q   <= '0;
      z_prev_q <= '0;
    end else begin
      z_s1_q   <= z_s1_d;
      z_s2_q   <= z_s2_d;
      z_prev_q <= z_prev_d;
    end
  end
`else
  assign idx_clear = '0;
`endif

  // A move of +1 / -1 along the Gray sequence is a step; both bits changing
  // at once cannot be resolved into a direction and is reported instead.
  always_comb begin
    cur_idx  = '0;
    prev_idx = '0;
    step_inc = '0;
    step_dec = '0;
    step_bad = '0;
    for (int n = 0; n < CH; n++) begin
      cur_idx[n]  = gray_idx(a_s2_q[n], b_s2_q[n]);
      prev_idx[n] = gray_idx(a_prev_q[n], b_prev_q[n]);
      step_inc[n] = (cur_idx[n] == prev_idx[n] + 2'd1);
      step_dec[n] = (cur_idx[n] == prev_idx[n] - 2'd1);
      step_bad[n] = (a_s2_q[n] ^ a_prev_q[n]) & (b_s2_q[n] ^ b_prev_q[n]);
    end
  end

  // Forced-zero conditions (index clear, degenerate PPR, count out of range
  // after PPR was lowered) override any step; otherwise wrap modulo PPR.
  always_comb begin
    count_d = count_q;
    err_d   = err_q | step_bad;
    for (int n = 0; n < CH; n++) begin
      if (idx_clear[n] || ppr_small || (count_q[n] >= PPR)) begin
        count_d[n] = '0;
      end else if (step_inc[n]) begin
        count_d[n] = (count_q[n] == ppr_m1) ? '0 : count_q[n] + PW'(1);
      end else if (step_dec[n]) begin
        count_d[n] = (count_q[n] == '0) ? ppr_m1 : count_q[n] - PW'(1);
      end
    end
  end

  // The >= compare keeps the divider bounded if Rate is lowered mid-count.
  // pwm, duty, frame and the frame counter are all computed from next-state
  // values so they line up in the same cycle.
  always_comb begin
    rate_m1 = Rate - 24'd1;
    tick    = (Rate <= 24'd1) || (div_q >= rate_m1);
    div_d   = tick ? '0 : div_q + 24'd1;
    wrap    = tick && (fcnt_q == '1);
    fcnt_d  = tick ? fcnt_q + PW'(1) : fcnt_q;
    frame_d = wrap;
    duty_d  = duty_q;
    pwm_d   = '0;
    for (int n = 0; n < CH; n++) begin
      if (wrap) begin
        duty_d[n] = count_q[n];
      end
      pwm_d[n] = (fcnt_d < duty_d[n]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_s1_q   <= '0;
      a_s2_q   <= '0;
      a_prev_q <= '0;
      b_s1_q   <= '0;
      b_s2_q   <= '0;
      b_prev_q <= '0;
      count_q  <= '0;
      duty_q   <= '0;
      err_q    <= '0;
      pwm_q    <= '0;
      div_q    <= '0;
      fcnt_q   <= '0;
      frame_q  <= 1'b0;
    end else begin
      a_s1_q   <= a_s1_d;
      a_s2_q   <= a_s2_d;
      a_prev_q <= a_prev_d;
      b_s1_q   <= b_s1_d;
      b_s2_q   <= b_s2_d;
      b_prev_q <= b_prev_d;
      count_q  <= count_d;
      duty_q   <= duty_d;
      err_q    <= err_d;
      pwm_q    <= pwm_d;
      div_q    <= div_d;
      fcnt_q   <= fcnt_d;
      frame_q  <= frame_d;
    end
  end

  assign Position = count_q;
  assign pwm      = pwm_q;
  assign frame    = frame_q;
  assign err      = err_q;

endmodule

// File: tb/tb_quad_pwm_bridge.sv
// tb_quad_pwm_bridge -- bench for quad_pwm_bridge (CH=2, PW=10).
// Works with and without QPB_INDEX_EN defined.
module tb_quad_pwm_bridge;
  localparam int CH = 2;
  localparam int PW = 10;

  typedef struct {
    string name;
    int    ppr;
    int    s0;
    int    s1;
    bit    ill1;
    int    exp0;
    int    exp1;
    int    exp_err;
  } vec_t;

  typedef struct {
    int p0;
    int p1;
    int e;
  } snap_t;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   phase [CH];
  int   cyc;

  quad_pwm_bridge_if #(.CH(CH), .PW(PW)) bus ();

  quad_pwm_bridge #(.CH(CH), .PW(PW)) dut (
    .clk      (clk),
    .reset    (reset),
    .A        (bus.A),
    .B        (bus.B),
`ifdef QPB_INDEX_EN
    .Z        (bus.Z),
`endif
    .PPR      (bus.PPR),
    .Rate     (bus.Rate),
    .Position (bus.Position),
    .pwm      (bus.pwm),
    .frame    (bus.frame),
    .err      (bus.err)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since the last reset release, used for frame timing.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [PW-1:0] posOf(input int ch);
    return bus.Position[ch*PW +: PW];
  endfunction

  // Puts each channel's phase counter onto A/B as the 00,01,11,10 sequence.
  task automatic drivePhases();
    for (int c = 0; c < CH; c++) begin
      bus.A[c] = ((phase[c] & 3) >= 2);
      bus.B[c] = ((phase[c] & 3) == 1) || ((phase[c] & 3) == 2);
    end
  endtask

  task automatic stepOnce(input int d0, input int d1);
    phase[0] += d0;
    phase[1] += d1;
    drivePhases();
    @(negedge clk);
  endtask

  // Steps both channels in lockstep, optional double-bit jump on channel 1,
  // then lets the synchroniser pipeline drain.
  task automatic applyStimulus(input int s0, input int s1, input bit ill1);
    int n0, n1, n;
    n0 = (s0 < 0) ? -s0 : s0;
    n1 = (s1 < 0) ? -s1 : s1;
    n  = (n0 > n1) ? n0 : n1;
    for (int k = 0; k < n; k++) begin
      stepOnce((k < n0) ? ((s0 < 0) ? -1 : 1) : 0,
               (k < n1) ? ((s1 < 0) ? -1 : 1) : 0);
    end
    if (ill1) stepOnce(0, 2);
    repeat (4) @(negedge clk);
  endtask

  task automatic doReset(input int ppr, input int rate);
    reset = 1'b0;
    for (int c = 0; c < CH; c++) phase[c] = 0;
    drivePhases();
`ifdef QPB_INDEX_EN
    bus.Z = '0;
`endif
    bus.PPR  = PW'(ppr);
    bus.Rate = 24'(rate);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic waitFrame(input int budget, output bit found);
    found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      if (bus.frame) found = 1'b1;
      else           @(negedge clk);
    end
  endtask

  // Walks one full frame from its start pulse, counting high cycles.
  task automatic measureFrame(input bit step1, output int hi0, output int hi1,
                              output int nfr);
    hi0 = 0;
    hi1 = 0;
    nfr = 0;
    for (int i = 0; i < 4096; i++) begin
      if (bus.frame)  nfr++;
      if (bus.pwm[0]) hi0++;
      if (bus.pwm[1]) hi1++;
      if (step1 && i >= 10 && i < 15) begin
        phase[1]++;
        drivePhases();
      end
      @(negedge clk);
    end
  endtask

  // Random walk checked cycle-exactly against an arithmetic model whose
  // result becomes visible three edges after the drive.
  task automatic randomRun(input int ppr, input int iters);
    int    m_cnt [CH];
    int    m_err;
    int    r, d;
    bit    found;
    snap_t s;
    snap_t q[$];
    doReset(ppr, 0);
    m_err = 0;
    for (int c = 0; c < CH; c++) m_cnt[c] = 0;
    for (int k = 0; k < 3; k++) q.push_back('{0, 0, 0});
    for (int t = 0; t < iters; t++) begin
      s = q.pop_front();
      checkOutput($sformatf("rand pos ppr=%0d t=%0d", ppr, t), bus.Position,
                  {12'd0, s.p1[PW-1:0], s.p0[PW-1:0]});
      checkOutput($sformatf("rand err ppr=%0d t=%0d", ppr, t), bus.err, s.e);
      for (int c = 0; c < CH; c++) begin
        r = int'($urandom_range(0, 39));
        if (r == 0)      d = 2;
        else if (r < 14) d = 1;
        else if (r < 28) d = -1;
        else             d = 0;
        phase[c] += d;
        if (d == 2) m_err |= (1 << c);
        else        m_cnt[c] = (m_cnt[c] + d + ppr) % ppr;
      end
      drivePhases();
      q.push_back('{m_cnt[0], m_cnt[1], m_err});
      @(negedge clk);
    end
    waitFrame(1200, found);
    checkOutput("rate0 frame seen", 32'(found), 1);
    checkOutput("rate0 frame period", 32'(cyc % 1024), 0);
  endtask

  vec_t tbl [8];

  // Main sequence: reset state, table vectors, multi-cycle corner cases,
  // PWM framing, optional index clear, then randomized walks.
  initial begin
    bit found;
    int hi0, hi1, nfr;

    tbl[0] = '{"fwd16",      600,  16,  0, 1'b0,  16,   0, 0};
    tbl[1] = '{"back16",     600, -16,  0, 1'b0,   0,   0, 0};
    tbl[2] = '{"under0",     600,  -1,  0, 1'b0, 599,   0, 0};
    tbl[3] = '{"overmax",    600,   1,  0, 1'b0,   0,   0, 0};
    tbl[4] = '{"both3m2",    600,   3, -2, 1'b0,   3, 598, 0};
    tbl[5] = '{"both5",      600,   5,  5, 1'b0,   8,   3, 0};
    tbl[6] = '{"illegal1",   600,   0,  0, 1'b1,   8,   3, 2};
    tbl[7] = '{"stickyerr",  600,   2,  0, 1'b0,  10,   3, 2};

    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    for (int c = 0; c < CH; c++) phase[c] = 0;
    drivePhases();
`ifdef QPB_INDEX_EN
    bus.Z = '0;
`endif
    bus.PPR  = PW'(600);
    bus.Rate = 24'd4;
    repeat (3) @(negedge clk);
    checkOutput("reset Position", bus.Position, 0);
    checkOutput("reset pwm", bus.pwm, 0);
    checkOutput("reset frame", bus.frame, 0);
    checkOutput("reset err", bus.err, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      bus.PPR = PW'(tbl[i].ppr);
      applyStimulus(tbl[i].s0, tbl[i].s1, tbl[i].ill1);
      checkOutput({tbl[i].name, " pos0"}, posOf(0), tbl[i].exp0);
      checkOutput({tbl[i].name, " pos1"}, posOf(1), tbl[i].exp1);
      checkOutput({tbl[i].name, " err"}, bus.err, tbl[i].exp_err);
    end

    phase[0]++;
    drivePhases();
    @(negedge clk);
    checkOutput("latency edge1", posOf(0), 10);
    @(negedge clk);
    checkOutput("latency edge2", posOf(0), 10);
    @(negedge clk);
    checkOutput("latency edge3", posOf(0), 11);

    applyStimulus(489, 0, 1'b0);
    checkOutput("count 500", posOf(0), 500);
    bus.PPR = PW'(400);
    @(negedge clk);
    checkOutput("ppr lowered pos0", posOf(0), 0);
    checkOutput("ppr lowered pos1", posOf(1), 3);
    bus.PPR = PW'(1);
    applyStimulus(3, 3, 1'b0);
    checkOutput("ppr1 pos0", posOf(0), 0);
    checkOutput("ppr1 pos1", posOf(1), 0);
    checkOutput("err still set", bus.err, 2);

    reset = 1'b0;
    #1;
    checkOutput("async reset err", bus.err, 0);
    checkOutput("async reset pos", bus.Position, 0);
    doReset(600, 4);

    applyStimulus(256, 0, 1'b0);
    checkOutput("pwm setup pos0", posOf(0), 256);
    waitFrame(5000, found);
    checkOutput("first frame seen", 32'(found), 1);
    checkOutput("first frame cycle", cyc, 4096);
    measureFrame(1'b1, hi0, hi1, nfr);
    checkOutput("frame1 pwm0 high", hi0, 1024);
    checkOutput("frame1 pwm1 high", hi1, 0);
    checkOutput("frame1 pulses", nfr, 1);
    checkOutput("frame1 period", bus.frame, 1);
    measureFrame(1'b0, hi0, hi1, nfr);
    checkOutput("frame2 pwm0 high", hi0, 1024);
    checkOutput("frame2 pwm1 high", hi1, 20);
    checkOutput("frame2 pulses", nfr, 1);
    checkOutput("frame2 period", bus.frame, 1);

`ifdef QPB_INDEX_EN
    applyStimulus(-133, 0, 1'b0);
    checkOutput("index setup pos0", posOf(0), 123);
    phase[0]++;
    bus.Z[0] = 1'b1;
    drivePhases();
    repeat (4) @(negedge clk);
    checkOutput("index clear pos0", posOf(0), 0);
    checkOutput("index clear pos1", posOf(1), 5);
`endif

    randomRun(int'($urandom_range(2, 5)), 400);
    randomRun(int'($urandom_range(6, 1023)), 400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
